// File: rtl/draw_cmd_pkg.sv
// Shared types and helpers for the draw command decoder: opcodes, FSM states,
// header field positions and the per-opcode command length table.
package draw_cmd_pkg;

    localparam int CMD_W       = 32;
    localparam int HDR_RSV_MSB = 31;
    localparam int HDR_RSV_LSB = 28;
    localparam int HDR_OP_MSB  = 27;
    localparam int HDR_OP_LSB  = 24;
    localparam int HDR_ARG_MSB = 23;

    typedef enum logic [3:0] {
        OPC_NOP         = 4'h0,
        OPC_SETFRAME    = 4'h1,
        OPC_SETDRAWAREA = 4'h2,
        OPC_SETCOLOR    = 4'h3,
        OPC_PATBLT      = 4'h4,
        OPC_BITBLT      = 4'h5,
        OPC_EODL        = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_ISSUE,
        ST_HALT
    } state_e;

    // Words per command including the header; 0 marks an unknown opcode.
    function automatic logic [1:0] cmd_len(input logic [3:0] opcode);
        case (opcode)
            OPC_NOP, OPC_EODL:                                  cmd_len = 2'd1;
            OPC_SETCOLOR:                                       cmd_len = 2'd2;
            OPC_SETFRAME, OPC_SETDRAWAREA, OPC_PATBLT, OPC_BITBLT: cmd_len = 2'd3;
            default:                                            cmd_len = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/draw_cmd_param_reg.sv
// Header plus two parameter capture registers, loaded by word index.
// Loading the header starts a new command, so it also clears both parameters.
module draw_cmd_param_reg
    import draw_cmd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic [1:0]       i_ld_idx,
    input  logic [CMD_W-1:0] i_ld_data,
    output logic [CMD_W-1:0] o_word0,
    output logic [CMD_W-1:0] o_word1,
    output logic [CMD_W-1:0] o_word2
);

    logic [CMD_W-1:0] r_word [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these are discrete flops, not a RAM, so they take the async
            // reset and the OP_* outputs they drive read 0 straight out of reset.
            for (int i = 0; i < 3; i++) r_word[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < 3; i++) r_word[i] <= '0;
        end else if (i_ld) begin
            case (i_ld_idx)
                2'd0: begin
                    r_word[0] <= i_ld_data;
                    r_word[1] <= '0;
                    r_word[2] <= '0;
                end
                2'd1:    r_word[1] <= i_ld_data;
                2'd2:    r_word[2] <= i_ld_data;
                default: ;
            endcase
        end
    end

    assign o_word0 = r_word[0];
    assign o_word1 = r_word[1];
    assign o_word2 = r_word[2];

endmodule

// File: rtl/draw_cmd_decoder.sv
// Draw command FIFO consumer: pops words, parses variable-length commands and
// issues one operation at a time. Optional OP_COUNT via DRAW_DEC_OPCOUNT_EN.
module draw_cmd_decoder
    import draw_cmd_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int STALL_W = 8
) (
    input  logic              CLK,
    input  logic              ARST,
    input  logic              REG_EXE,
    input  logic              REG_RST,
    output logic              CMD_RD_EN,
    input  logic [CMD_W-1:0]  CMD_RDATA,
    input  logic              CMD_EMPTY,
    output logic              OP_VALID,
    input  logic              OP_READY,
    output logic [3:0]        OP_CODE,
    output logic [23:0]       OP_HDR,
    output logic [CMD_W-1:0]  OP_P1,
    output logic [CMD_W-1:0]  OP_P2,
    output logic              DEC_BUSY,
    output logic              EODL_PULSE,
    output logic              CMD_ERR,
    output logic              DEC_STALL
`ifdef DRAW_DEC_OPCOUNT_EN
    ,
    output logic [CNT_W-1:0]  OP_COUNT
`endif
);

    state_e             r_state;
    logic [1:0]         r_idx;
    logic               r_op_valid;
    logic               r_eodl;
    logic               r_err;
    logic [STALL_W-1:0] r_stall;

    logic [CMD_W-1:0]   w_word0;
    logic [CMD_W-1:0]   w_word1;
    logic [CMD_W-1:0]   w_word2;
    logic [CMD_W-1:0]   w_hdr_word;
    logic [3:0]         w_opcode;
    logic [1:0]         w_len;
    logic               w_pop;
    logic               w_last;
    logic               w_illegal;
    logic               w_eodl_dec;

    // Pop is combinational so the word lands exactly in the following CAPTURE cycle.
    assign w_pop = (r_state == ST_FETCH) && REG_EXE && !CMD_EMPTY && !REG_RST;

    // The header is on the bus at index 0; afterwards it comes from the capture register.
    assign w_hdr_word = (r_idx == 2'd0) ? CMD_RDATA : w_word0;
    assign w_opcode   = w_hdr_word[HDR_OP_MSB:HDR_OP_LSB];
    assign w_len      = (w_hdr_word[HDR_RSV_MSB:HDR_RSV_LSB] == 4'h0) ? cmd_len(w_opcode) : 2'd0;
    assign w_illegal  = (w_len == 2'd0);
    assign w_last     = ((r_idx + 2'd1) == w_len);
    assign w_eodl_dec = (r_state == ST_CAPTURE) && !w_illegal && w_last && (w_opcode == OPC_EODL);

    draw_cmd_param_reg u_param_reg (
        .clk       (CLK),
        .rst       (ARST),
        .i_clr     (REG_RST),
        .i_ld      (r_state == ST_CAPTURE),
        .i_ld_idx  (r_idx),
        .i_ld_data (CMD_RDATA),
        .o_word0   (w_word0),
        .o_word1   (w_word1),
        .o_word2   (w_word2)
    );

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_op_valid <= 1'b0;
            r_eodl     <= 1'b0;
            r_err      <= 1'b0;
            r_stall    <= '0;
        end else if (REG_RST) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_op_valid <= 1'b0;
            r_eodl     <= 1'b0;
            r_err      <= 1'b0;
            r_stall    <= '0;
        end else begin
            r_eodl <= 1'b0;

            if (w_pop)
                r_stall <= '0;
            else if ((r_state == ST_FETCH) && CMD_EMPTY && (r_idx != 2'd0) && !(&r_stall))
                r_stall <= r_stall + STALL_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (REG_EXE) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_pop)
                        r_state <= ST_CAPTURE;
                    else if (!REG_EXE && (r_idx == 2'd0))
                        r_state <= ST_IDLE;
                end
                ST_CAPTURE: begin
                    r_idx <= r_idx + 2'd1;
                    if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= ST_HALT;
                    end else if (!w_last) begin
                        r_state <= ST_FETCH;
                    end else if (w_opcode == OPC_NOP) begin
                        r_idx   <= 2'd0;
                        r_state <= ST_FETCH;
                    end else if (w_opcode == OPC_EODL) begin
                        r_idx   <= 2'd0;
                        r_eodl  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_op_valid <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (OP_READY) begin
                        r_op_valid <= 1'b0;
                        r_idx      <= 2'd0;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_HALT: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DRAW_DEC_OPCOUNT_EN
    logic [CNT_W-1:0] r_op_count;

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST)
            r_op_count <= '0;
        else if (REG_RST || w_eodl_dec)
            r_op_count <= '0;
        else if (r_op_valid && OP_READY)
            r_op_count <= r_op_count + CNT_W'(1);
    end

    assign OP_COUNT = r_op_count;
`else
    // CNT_W only sizes OP_COUNT; keep it referenced when the counter is compiled out.
    localparam int unused_cnt_w = CNT_W;
    logic unused_eodl_dec;
    assign unused_eodl_dec = w_eodl_dec;
`endif

    assign CMD_RD_EN  = w_pop;
    assign OP_VALID   = r_op_valid;
    assign OP_CODE    = w_word0[HDR_OP_MSB:HDR_OP_LSB];
    assign OP_HDR     = w_word0[HDR_ARG_MSB:0];
    assign OP_P1      = w_word1;
    assign OP_P2      = w_word2;
    assign DEC_BUSY   = (r_state != ST_IDLE);
    assign EODL_PULSE = r_eodl;
    assign CMD_ERR    = r_err;
    assign DEC_STALL  = &r_stall;

endmodule

// File: tb/tb_draw_cmd_decoder.sv
// Self-checking bench for draw_cmd_decoder: FIFO model, single-command vector
// table, directed multi-cycle sequences and a randomized run against a parser model.
module tb_draw_cmd_decoder;

    typedef struct packed {
        logic [3:0]  code;
        logic [23:0] hdr;
        logic [31:0] p1;
        logic [31:0] p2;
    } op_t;

    typedef struct {
        logic [31:0] w0, w1, w2;
        int          npush;
        int          npop;
        bit          issue;
        bit          eodl;
        bit          err;
        logic [3:0]  code;
        logic [23:0] hdr;
        logic [31:0] p1, p2;
    } vec_t;

    logic        CLK = 1'b0;
    logic        ARST = 1'b1;
    logic        REG_EXE = 1'b0;
    logic        REG_RST = 1'b0;
    logic        CMD_RD_EN;
    logic [31:0] CMD_RDATA = '0;
    logic        CMD_EMPTY = 1'b1;
    logic        OP_VALID;
    logic        OP_READY = 1'b0;
    logic [3:0]  OP_CODE;
    logic [23:0] OP_HDR;
    logic [31:0] OP_P1, OP_P2;
    logic        DEC_BUSY, EODL_PULSE, CMD_ERR, DEC_STALL;
`ifdef DRAW_DEC_OPCOUNT_EN
    logic [15:0] op_count;
`endif

    draw_cmd_decoder dut (
        .CLK        (CLK),
        .ARST       (ARST),
        .REG_EXE    (REG_EXE),
        .REG_RST    (REG_RST),
        .CMD_RD_EN  (CMD_RD_EN),
        .CMD_RDATA  (CMD_RDATA),
        .CMD_EMPTY  (CMD_EMPTY),
        .OP_VALID   (OP_VALID),
        .OP_READY   (OP_READY),
        .OP_CODE    (OP_CODE),
        .OP_HDR     (OP_HDR),
        .OP_P1      (OP_P1),
        .OP_P2      (OP_P2),
        .DEC_BUSY   (DEC_BUSY),
        .EODL_PULSE (EODL_PULSE),
        .CMD_ERR    (CMD_ERR),
        .DEC_STALL  (DEC_STALL)
`ifdef DRAW_DEC_OPCOUNT_EN
        ,
        .OP_COUNT   (op_count)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] fifo_q[$];
    op_t         hs_log[$];
    int          pop_cnt, eodl_cnt, b2b_err, underflow, stable_err, busy_eodl_err;
    int          first_stall, last_pop_cyc;
    bit          rd_last, prev_vwait;
    op_t         prev_op;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample handshake/pop before the edge, then apply the FIFO pop
    // (data valid the cycle after read enable) and record observations.
    task automatic tick();
        logic rd, hs;
        op_t  cur;
        @(negedge CLK);
        rd  = CMD_RD_EN;
        hs  = OP_VALID && OP_READY;
        cur = '{OP_CODE, OP_HDR, OP_P1, OP_P2};
        if (prev_vwait && OP_VALID && (cur != prev_op)) stable_err++;
        prev_vwait = OP_VALID && !OP_READY;
        prev_op    = cur;
        @(posedge CLK);
        #1;
        cyc++;
        if (rd) begin
            if (rd_last) b2b_err++;
            if (fifo_q.size() == 0) underflow++;
            else CMD_RDATA = fifo_q.pop_front();
            pop_cnt++;
            last_pop_cyc = cyc;
        end
        rd_last   = rd;
        CMD_EMPTY = (fifo_q.size() == 0);
        if (hs) hs_log.push_back(cur);
        if (EODL_PULSE) begin
            eodl_cnt++;
            if (DEC_BUSY) busy_eodl_err++;
        end
        if (DEC_STALL && first_stall < 0) first_stall = cyc;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        CMD_EMPTY = 1'b0;
    endtask

    task automatic do_reset();
        ARST     = 1'b1;
        REG_EXE  = 1'b0;
        REG_RST  = 1'b0;
        OP_READY = 1'b0;
        fifo_q.delete();
        CMD_EMPTY = 1'b1;
        tick();
        tick();
        ARST = 1'b0;
        hs_log.delete();
        pop_cnt = 0; eodl_cnt = 0; b2b_err = 0; underflow = 0;
        stable_err = 0; busy_eodl_err = 0; first_stall = -1; last_pop_cyc = 0;
        rd_last = 1'b0; prev_vwait = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!OP_VALID && n < budget) begin
            tick();
            n++;
        end
        check({name, "_valid_seen"}, OP_VALID, 1);
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n = 0;
        while (pop_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_pops_seen"}, pop_cnt, target);
    endtask

    task automatic check_protocol(input string name);
        check({name, "_b2b_pops"}, b2b_err, 0);
        check({name, "_underflow"}, underflow, 0);
        check({name, "_op_stable"}, stable_err, 0);
    endtask

    // Reference model: length of a command from its header, per the opcode table.
    function automatic int spec_len(input logic [31:0] hdr);
        if (hdr[31:28] != 4'h0) return 0;
        case (hdr[27:24])
            4'h0, 4'hF:             return 1;
            4'h3:                   return 2;
            4'h1, 4'h2, 4'h4, 4'h5: return 3;
            default:                return 0;
        endcase
    endfunction

    vec_t        tbl[10];
    op_t         exp_q[$];
    logic [31:0] words[$];
    logic [3:0]  opcs[8];

    initial begin
        tbl[0] = '{32'h00000000, 32'h0, 32'h0, 1, 1, 0, 0, 0, 4'h0, 24'h0, 32'h0, 32'h0};
        tbl[1] = '{32'h01ABCDEF, 32'h11111111, 32'h22222222, 3, 3, 1, 0, 0, 4'h1, 24'hABCDEF, 32'h11111111, 32'h22222222};
        tbl[2] = '{32'h02000010, 32'h00050006, 32'h01000200, 3, 3, 1, 0, 0, 4'h2, 24'h000010, 32'h00050006, 32'h01000200};
        tbl[3] = '{32'h03000000, 32'hDEADBEEF, 32'h0, 2, 2, 1, 0, 0, 4'h3, 24'h000000, 32'hDEADBEEF, 32'h0};
        tbl[4] = '{32'h04123456, 32'h0000000A, 32'h0000000B, 3, 3, 1, 0, 0, 4'h4, 24'h123456, 32'h0000000A, 32'h0000000B};
        tbl[5] = '{32'h05654321, 32'h00010002, 32'h00030004, 3, 3, 1, 0, 0, 4'h5, 24'h654321, 32'h00010002, 32'h00030004};
        tbl[6] = '{32'h0F000000, 32'h0, 32'h0, 1, 1, 0, 1, 0, 4'h0, 24'h0, 32'h0, 32'h0};
        tbl[7] = '{32'h06000000, 32'h00000000, 32'h0, 2, 1, 0, 0, 1, 4'h0, 24'h0, 32'h0, 32'h0};
        tbl[8] = '{32'h10000000, 32'h00000000, 32'h0, 2, 1, 0, 0, 1, 4'h0, 24'h0, 32'h0, 32'h0};
        tbl[9] = '{32'h0E000000, 32'h00000000, 32'h0, 2, 1, 0, 0, 1, 4'h0, 24'h0, 32'h0, 32'h0};

        // Reset state
        do_reset();
        check("rst_busy", DEC_BUSY, 0);
        check("rst_valid", OP_VALID, 0);
        check("rst_rd_en", CMD_RD_EN, 0);
        check("rst_err", CMD_ERR, 0);
        check("rst_stall", DEC_STALL, 0);
        check("rst_eodl", EODL_PULSE, 0);
        check("rst_fields", {OP_CODE, OP_HDR, OP_P1}, 0);
        check("rst_p2", OP_P2, 0);

        // Single-command vector table
        for (int i = 0; i < 10; i++) begin
            do_reset();
            REG_EXE  = 1'b1;
            OP_READY = 1'b1;
            push(tbl[i].w0);
            if (tbl[i].npush > 1) push(tbl[i].w1);
            if (tbl[i].npush > 2) push(tbl[i].w2);
            repeat (20) tick();
            check($sformatf("tbl%0d_pops", i), pop_cnt, tbl[i].npop);
            check($sformatf("tbl%0d_handshakes", i), hs_log.size(), int'(tbl[i].issue));
            check($sformatf("tbl%0d_eodl", i), eodl_cnt, int'(tbl[i].eodl));
            check($sformatf("tbl%0d_err", i), CMD_ERR, tbl[i].err);
            if (tbl[i].issue && hs_log.size() > 0) begin
                check($sformatf("tbl%0d_code_hdr", i), {hs_log[0].code, hs_log[0].hdr}, {tbl[i].code, tbl[i].hdr});
                check($sformatf("tbl%0d_p1", i), hs_log[0].p1, tbl[i].p1);
                check($sformatf("tbl%0d_p2", i), hs_log[0].p2, tbl[i].p2);
            end
            check_protocol($sformatf("tbl%0d", i));
        end

        // 1: NOP then EODL
        do_reset();
        REG_EXE = 1'b1;
        push(32'h00000000);
        push(32'h0F000000);
        repeat (12) tick();
        check("t1_pops", pop_cnt, 2);
        check("t1_handshakes", hs_log.size(), 0);
        check("t1_eodl_cycles", eodl_cnt, 1);
        check("t1_idle_at_eodl", busy_eodl_err, 0);
        REG_EXE = 1'b0;
        repeat (3) tick();
        check("t1_busy_after", DEC_BUSY, 0);

        // 2: PATBLT held while OP_READY low
        do_reset();
        REG_EXE = 1'b1;
        push(32'h04000000);
        push(32'h00100020);
        push(32'h00400030);
        wait_valid(20, "t2");
        check("t2_latency", cyc - last_pop_cyc, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            check($sformatf("t2_hold%0d_valid", k), OP_VALID, 1);
            check($sformatf("t2_hold%0d_code", k), OP_CODE, 4'h4);
            check($sformatf("t2_hold%0d_p1", k), OP_P1, 32'h00100020);
            check($sformatf("t2_hold%0d_p2", k), OP_P2, 32'h00400030);
        end
        OP_READY = 1'b1;
        tick();
        check("t2_valid_drop", OP_VALID, 0);
        repeat (3) tick();
        check("t2_handshakes", hs_log.size(), 1);
        check_protocol("t2");

        // 3: SETCOLOR starved mid-command
        do_reset();
        REG_EXE  = 1'b1;
        OP_READY = 1'b1;
        push(32'h03000000);
        wait_pops(1, 10, "t3_hdr");
        repeat (300) tick();
        check("t3_no_pops_empty", pop_cnt, 1);
        check("t3_stall_onset", first_stall - last_pop_cyc, 256);
        check("t3_stall_high", DEC_STALL, 1);
        push(32'h00FF00FF);
        wait_valid(10, "t3");
        check("t3_p1", OP_P1, 32'h00FF00FF);
        check("t3_p2", OP_P2, 32'h0);
        check("t3_stall_cleared", DEC_STALL, 0);

        // 4: illegal opcode halts until soft reset
        do_reset();
        REG_EXE = 1'b1;
        push(32'h07000000);
        push(32'h00000000);
        push(32'h0F000000);
        repeat (20) tick();
        check("t4_err", CMD_ERR, 1);
        check("t4_pops", pop_cnt, 1);
        check("t4_busy_halt", DEC_BUSY, 1);
        check("t4_no_valid", OP_VALID, 0);
        REG_EXE = 1'b0;
        REG_RST = 1'b1;
        tick();
        REG_RST = 1'b0;
        tick();
        check("t4_err_cleared", CMD_ERR, 0);
        check("t4_idle", DEC_BUSY, 0);

        // 5: REG_RST during BITBLT issue
        do_reset();
        REG_EXE = 1'b1;
        push(32'h05000001);
        push(32'hAAAA5555);
        push(32'h12345678);
        push(32'h03000002);
        push(32'h0000BEEF);
        wait_valid(20, "t5_bitblt");
        repeat (2) tick();
        REG_RST = 1'b1;
        tick();
        REG_RST = 1'b0;
        check("t5_valid_drop", OP_VALID, 0);
        check("t5_no_handshake", hs_log.size(), 0);
        OP_READY = 1'b1;
        wait_valid(20, "t5_next");
        check("t5_code_hdr", {OP_CODE, OP_HDR}, {4'h3, 24'h000002});
        check("t5_p1", OP_P1, 32'h0000BEEF);
        check("t5_p2", OP_P2, 32'h0);
        repeat (2) tick();
        check("t5_handshakes", hs_log.size(), 1);

        // 6: REG_EXE drops mid SETFRAME
        do_reset();
        REG_EXE  = 1'b1;
        OP_READY = 1'b1;
        push(32'h01000042);
        wait_pops(1, 10, "t6_hdr");
        REG_EXE = 1'b0;
        push(32'h01234567);
        push(32'h89ABCDEF);
        repeat (10) tick();
        check("t6_pops_withheld", pop_cnt, 1);
        check("t6_busy_held", DEC_BUSY, 1);
        REG_EXE = 1'b1;
        wait_valid(20, "t6");
        check("t6_code_hdr", {OP_CODE, OP_HDR}, {4'h1, 24'h000042});
        check("t6_p1", OP_P1, 32'h01234567);
        check("t6_p2", OP_P2, 32'h89ABCDEF);

        // Randomized command stream against the parser model
        do_reset();
        opcs = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF, 4'h3};
        words.delete();
        exp_q.delete();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] h;
            h = {4'h0, opcs[$urandom_range(0, 7)], 24'($urandom)};
            words.push_back(h);
            for (int p = 1; p < spec_len(h); p++) words.push_back($urandom);
        end
        begin
            int i = 0;
            int exp_eodl = 0;
            int wi = 0;
            int budget = 0;
            while (i < words.size()) begin
                logic [31:0] h;
                int          len;
                op_t         e;
                h   = words[i];
                len = spec_len(h);
                e   = '{h[27:24], h[23:0], (len > 1) ? words[i+1] : 32'h0, (len > 2) ? words[i+2] : 32'h0};
                if (h[27:24] == 4'hF) exp_eodl++;
                else if (h[27:24] != 4'h0) exp_q.push_back(e);
                i += len;
            end
            REG_EXE = 1'b1;
            while (!(wi == words.size() && fifo_q.size() == 0 &&
                     hs_log.size() >= exp_q.size() && !OP_VALID) && budget < 6000) begin
                if (wi < words.size() && $urandom_range(0, 2) == 0) begin
                    push(words[wi]);
                    wi++;
                end
                OP_READY = ($urandom_range(0, 1) == 1);
                tick();
                budget++;
            end
            repeat (6) tick();
            check("rnd_finished", budget < 6000, 1);
            check("rnd_pops", pop_cnt, words.size());
            check("rnd_op_count", hs_log.size(), exp_q.size());
            check("rnd_eodl_count", eodl_cnt, exp_eodl);
            check("rnd_err", CMD_ERR, 0);
            for (int k = 0; k < exp_q.size() && k < hs_log.size(); k++) begin
                check($sformatf("rnd_op%0d_code_hdr", k), {hs_log[k].code, hs_log[k].hdr}, {exp_q[k].code, exp_q[k].hdr});
                check($sformatf("rnd_op%0d_p1", k), hs_log[k].p1, exp_q[k].p1);
                check($sformatf("rnd_op%0d_p2", k), hs_log[k].p2, exp_q[k].p2);
            end
            check_protocol("rnd");
            check("rnd_idle_at_eodl", busy_eodl_err, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
